// File: rtl/sys_array_pkg.sv
// sys_array_pkg
// Shared definitions for the systolic-array sequencing controller:
//   - state_t  : controller phases IDLE -> CLEAR -> LOAD -> DRAIN -> OUT
//   - LEN_W    : default width of the stream length and buffer addresses
//   - drainLen : number of DRAIN cycles needed after the last operand read
package sys_array_pkg;

    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        DRAIN,
        OUT
    } state_t;

    // Covers the operand buffer latency, the skew across the array in both
    // directions, and the array output register.
    function automatic int drainLen(input int sysDim, input int rdLat);
        return rdLat + 2 * sysDim;
    endfunction

endpackage

// File: rtl/sys_array_cnt.sv
// sys_array_cnt
// Loadable down-counter with a terminal-count flag. Used to time the LOAD and
// DRAIN phases of the scheduler. The counter stops at zero.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (count -> 0)
//   load       load loadValue (has priority over en)
//   loadValue  value to load
//   en         decrement by one while the count is non-zero
//   tc         high while the count is zero
module sys_array_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] loadValue,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= loadValue;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign tc = (count_reg == '0);

endmodule

// File: rtl/sys_array_sched.sv
// sys_array_sched
// Sequencing controller for a SysDimension x SysDimension systolic array.
// Accepts a tile command with stream length K, clears the array, issues K
// operand read addresses, keeps the array enabled through fill and drain, then
// presents the finished tile with a valid/ready handshake.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start, streamLength       command pulse and K (sampled in IDLE only)
//   abort                     synchronous abort back to IDLE, no done
//   busy                      high outside IDLE
//   array_clr, array_en       array accumulator clear and enable
//   w_rd_en/f_rd_en           weight / feature buffer read strobes
//   w_rd_addr/f_rd_addr       weight / feature buffer read addresses
//   out_valid, out_ready      finished-tile handshake
//   done                      one-cycle completion pulse
//   perf_busy, perf_stall     only with SYS_ARRAY_SCHED_PERF_EN defined:
//                             saturating busy-cycle and output-stall counters
// All outputs are registered from the next state, so they line up with the
// state register.
module sys_array_sched #(
    parameter int SysDimension = 16,
    parameter int LEN_W        = sys_array_pkg::LEN_W,
    parameter int RD_LAT       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] streamLength,
    input  logic             abort,
    output logic             busy,
    output logic             array_clr,
    output logic             array_en,
    output logic             w_rd_en,
    output logic             f_rd_en,
    output logic [LEN_W-1:0] w_rd_addr,
    output logic [LEN_W-1:0] f_rd_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done
`ifdef SYS_ARRAY_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_busy,
    output logic [31:0]      perf_stall
`endif
);

    import sys_array_pkg::*;

    localparam int D       = drainLen(SysDimension, RD_LAT);
    localparam int DRAIN_W = $clog2(D + 1);

    state_t state_reg, state_next;

    logic             busy_reg, busy_next;
    logic             clr_reg, clr_next;
    logic             en_reg, en_next;
    logic             rd_reg, rd_next;
    logic [LEN_W-1:0] addr_reg, addr_next;
    logic             valid_reg, valid_next;
    logic             done_reg, done_next;

    logic cnt_load;
    logic load_tc;
    logic drain_tc;

    // Both phase counters are armed when the command is accepted; each only
    // counts down while its own phase is active. Loading K-1 / D-1 gives
    // exactly K / D cycles, leaving on the cycle the count reads zero.
    sys_array_cnt #(.W(LEN_W)) u_load_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .loadValue (streamLength - LEN_W'(1)),
        .en        (state_reg == LOAD),
        .tc        (load_tc)
    );

    sys_array_cnt #(.W(DRAIN_W)) u_drain_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .loadValue (DRAIN_W'(D - 1)),
        .en        (state_reg == DRAIN),
        .tc        (drain_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        cnt_load   = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (streamLength != '0) begin
                            state_next = CLEAR;
                            cnt_load   = 1'b1;
                        end else begin
                            // Empty tile: nothing to compute, just acknowledge.
                            done_next = 1'b1;
                        end
                    end
                end
                CLEAR: state_next = LOAD;
                LOAD:  if (load_tc) state_next = DRAIN;
                DRAIN: if (drain_tc) state_next = OUT;
                OUT: begin
                    if (valid_reg && out_ready) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        busy_next  = (state_next != IDLE);
        clr_next   = (state_next == CLEAR);
        en_next    = (state_next == LOAD) || (state_next == DRAIN);
        rd_next    = (state_next == LOAD);
        valid_next = (state_next == OUT);

        // Address runs 0..K-1 through LOAD and freezes during DRAIN.
        addr_next = '0;
        if (state_next == LOAD) begin
            addr_next = (state_reg == LOAD) ? addr_reg + LEN_W'(1) : '0;
        end else if (state_next == DRAIN) begin
            addr_next = addr_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg  <= 1'b0;
            clr_reg   <= 1'b0;
            en_reg    <= 1'b0;
            rd_reg    <= 1'b0;
            addr_reg  <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            busy_reg  <= busy_next;
            clr_reg   <= clr_next;
            en_reg    <= en_next;
            rd_reg    <= rd_next;
            addr_reg  <= addr_next;
            valid_reg <= valid_next;
            done_reg  <= done_next;
        end
    end

    assign busy      = busy_reg;
    assign array_clr = clr_reg;
    assign array_en  = en_reg;
    assign w_rd_en   = rd_reg;
    assign f_rd_en   = rd_reg;
    assign w_rd_addr = addr_reg;
    assign f_rd_addr = addr_reg;
    assign out_valid = valid_reg;
    assign done      = done_reg;

`ifdef SYS_ARRAY_SCHED_PERF_EN
    logic [31:0] perf_busy_reg;
    logic [31:0] perf_stall_reg;
    logic        start_acc;

    assign start_acc = (state_reg == IDLE) && start && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_busy_reg  <= '0;
            perf_stall_reg <= '0;
        end else if (start_acc) begin
            perf_busy_reg  <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (busy_reg && (perf_busy_reg != '1)) begin
                perf_busy_reg <= perf_busy_reg + 32'd1;
            end
            if (valid_reg && !out_ready && (perf_stall_reg != '1)) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_busy  = perf_busy_reg;
    assign perf_stall = perf_stall_reg;
`endif

endmodule

// File: tb/tb_sys_array_sched.sv
// tb_sys_array_sched
// Directed bench for sys_array_sched with SysDimension=4, RD_LAT=1 (D=9).
// Inputs change on the falling edge; outputs are observed on the falling edge,
// so the n-th observation after a start shows the value "at Tn".
module tb_sys_array_sched;

    localparam int SD = 4;
    localparam int RL = 1;
    localparam int LW = 16;
    localparam int D  = RL + 2 * SD;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] streamLength = '0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, array_clr, array_en, w_rd_en, f_rd_en, out_valid, done;
    logic [LW-1:0] w_rd_addr, f_rd_addr;
`ifdef SYS_ARRAY_SCHED_PERF_EN
    logic [31:0]   perf_busy, perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sys_array_sched #(
        .SysDimension (SD),
        .LEN_W        (LW),
        .RD_LAT       (RL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .streamLength (streamLength),
        .abort        (abort),
        .busy         (busy),
        .array_clr    (array_clr),
        .array_en     (array_en),
        .w_rd_en      (w_rd_en),
        .f_rd_en      (f_rd_en),
        .w_rd_addr    (w_rd_addr),
        .f_rd_addr    (f_rd_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .done         (done)
`ifdef SYS_ARRAY_SCHED_PERF_EN
        ,
        .perf_busy    (perf_busy),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_cycle(input string tag, input bit e_busy, input bit e_clr,
                             input bit e_en, input bit e_rd, input bit e_valid,
                             input bit e_done, input bit addr_chk, input int e_addr);
        check_val({tag, ".busy"},      32'(busy),      32'(e_busy));
        check_val({tag, ".array_clr"}, 32'(array_clr), 32'(e_clr));
        check_val({tag, ".array_en"},  32'(array_en),  32'(e_en));
        check_val({tag, ".w_rd_en"},   32'(w_rd_en),   32'(e_rd));
        check_val({tag, ".f_rd_en"},   32'(f_rd_en),   32'(e_rd));
        check_val({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
        check_val({tag, ".done"},      32'(done),      32'(e_done));
        if (addr_chk) begin
            check_val({tag, ".w_rd_addr"}, 32'(w_rd_addr), 32'(e_addr));
            check_val({tag, ".f_rd_addr"}, 32'(f_rd_addr), 32'(e_addr));
        end
    endtask

    // Follows one tile whose start is already driven (accepted at the next
    // rising edge, T0). Expected timeline for stream length k:
    //   clr T1, rd T2..T(k+1), en T2..T(k+D+1),
    //   valid T(k+D+2)..T(k+D+2+stall), done T(k+D+3+stall).
    // cut>0 stops after observation T(cut); poke re-asserts start mid-LOAD;
    // chain asserts the next start in the done cycle.
    task automatic run_tile(input string tag, input int k, input int stall,
                            input bit chain, input int k_next,
                            input int cut, input bit poke);
        int v_end;
        int last;
        int e_addr;
        v_end = k + D + 2 + stall;
        last  = (cut > 0) ? cut : v_end + 1;
        out_ready = (stall == 0);
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            if (n <= k + 1)          e_addr = n - 2;
            else if (n <= k + D + 1) e_addr = k - 1;
            else                     e_addr = 0;
            exp_cycle($sformatf("%s.T%0d", tag, n),
                      n <= v_end, n == 1, (n >= 2) && (n <= k + D + 1),
                      (n >= 2) && (n <= k + 1), (n >= k + D + 2) && (n <= v_end),
                      n == v_end + 1,
                      ((n >= 2) && (n <= k + D + 1)) || (n == v_end + 1), e_addr);
            if (n == 1) start = 1'b0;
            if (poke && n == 3) begin
                start = 1'b1;
                streamLength = LW'(2);
            end
            if (poke && n == 4) start = 1'b0;
            if (n == v_end) out_ready = 1'b1;
            if (n == v_end + 1) begin
`ifdef SYS_ARRAY_SCHED_PERF_EN
                check_val({tag, ".perf_stall"}, perf_stall, 32'(stall));
                check_val({tag, ".perf_busy"},  perf_busy,  32'(v_end));
`endif
                if (chain) begin
                    start = 1'b1;
                    streamLength = LW'(k_next);
                end
            end
        end
        $display("tile %s K=%0d stall=%0d observed through T%0d", tag, k, stall, last);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        exp_cycle("reset", 0, 0, 0, 0, 0, 0, 1, 0);
        rst = 1'b1;
        @(negedge clk);
        exp_cycle("idle", 0, 0, 0, 0, 0, 0, 1, 0);

        // K=8 with out_ready high: out_valid T19, done T20
        start = 1'b1;
        streamLength = LW'(8);
        run_tile("k8", 8, 0, 0, 0, 0, 0);

        // K=8 with a 5-cycle consumer stall: done T25
        start = 1'b1;
        streamLength = LW'(8);
        run_tile("k8stall", 8, 5, 0, 0, 0, 0);

        // K=0: done at T1, nothing else moves
        start = 1'b1;
        streamLength = '0;
        @(negedge clk);
        exp_cycle("k0.T1", 0, 0, 0, 0, 0, 1, 1, 0);
        start = 1'b0;
        @(negedge clk);
        exp_cycle("k0.T2", 0, 0, 0, 0, 0, 0, 1, 0);
        $display("tile k0 K=0 done pulse only");

        // Abort sampled at T6 during LOAD, with a simultaneous start
        start = 1'b1;
        streamLength = LW'(8);
        run_tile("abort", 8, 0, 0, 0, 6, 0);
        abort = 1'b1;
        start = 1'b1;
        streamLength = LW'(4);
        @(negedge clk);
        exp_cycle("abort.T7", 0, 0, 0, 0, 0, 0, 1, 0);
        abort = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_cycle($sformatf("abort.after%0d", i), 0, 0, 0, 0, 0, 0, 1, 0);
        end
        $display("tile abort aborted in LOAD");

        // Restart after abort, K=3: done 15 cycles after start
        start = 1'b1;
        streamLength = LW'(3);
        run_tile("k3restart", 3, 0, 0, 0, 0, 0);

        // K=4 with start poked during LOAD, then reset asserted in DRAIN (T7)
        start = 1'b1;
        streamLength = LW'(4);
        run_tile("rstdrain", 4, 0, 0, 0, 7, 1);
        rst = 1'b0;
        #1;
        exp_cycle("rstdrain.async", 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_cycle($sformatf("rstdrain.after%0d", i), 0, 0, 0, 0, 0, 0, 1, 0);
        end
        $display("tile rstdrain reset during DRAIN");

        // Back-to-back: K=2 then K=5 started in the done cycle
        start = 1'b1;
        streamLength = LW'(2);
        run_tile("b2b.a", 2, 0, 1, 5, 0, 0);
        run_tile("b2b.b", 5, 0, 0, 0, 0, 0);
        @(negedge clk);
        exp_cycle("b2b.idle", 0, 0, 0, 0, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_array_sched.md
# sys_array_sched

Sequencing controller for the SysDimension x SysDimension systolic matrix-multiply array. It accepts a tile command with a common stream length, then clears the array. It issues K read addresses to the weight and feature buffers, holds the array enable through the skewed fill and drain, and presents the finished output row with a valid/ready handshake. It sits between the PPO layer scheduler (command side) and the array plus its operand buffers (datapath side).

## Interface
- SysDimension, 16, array edge; sets the drain length
- LEN_W, 16, width of stream length and buffer addresses
- RD_LAT, 1, operand buffer read latency in cycles (1..4)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  command pulse; sampled only in IDLE
- streamLength  in  LEN_W  K, the common layer size; latched when start is accepted
- abort  in  1  synchronous abort; returns to IDLE from any state
- busy  out  1  high in every state except IDLE
- array_clr  out  1  one-cycle accumulator clear to the array
- array_en  out  1  array enable
- w_rd_en, f_rd_en  out  1  buffer read strobes
- w_rd_addr, f_rd_addr  out  LEN_W  buffer read addresses
- out_valid  out  1  array output register holds a finished tile
- out_ready  in  1  consumer accepts the tile
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE -> CLEAR -> LOAD -> DRAIN -> OUT -> IDLE.
- IDLE: all outputs 0. start=1 with K>0: latch K and go to CLEAR. start=1 with K=0: stay in IDLE and pulse done next cycle; array_en and out_valid are never raised.
- CLEAR: exactly 1 cycle. array_clr=1, then go to LOAD.
- LOAD: exactly K cycles. w_rd_en=f_rd_en=1, array_en=1. Both addresses equal the counter k = 0..K-1, incrementing by 1 per cycle.
- DRAIN: exactly D = RD_LAT + 2*SysDimension cycles. array_en=1, rd_en=0. Addresses hold their last value. Covers buffer latency, skew and the array output register.
- OUT: out_valid=1 and array_en=0, so the array holds its result. On out_valid&&out_ready, go to IDLE and pulse done in the first IDLE cycle.
- abort: highest priority. Takes effect at the next edge in any state and goes to IDLE. No done pulse. out_valid drops. A start in the same cycle as abort is ignored.
- start while busy is ignored, with no queuing.
- Counter widths: the LOAD counter is LEN_W bits. The DRAIN counter is ceil(log2(D+1)) bits. The counters never wrap, because K is at most 2^LEN_W-1.

## Timing
- Reset: all outputs 0, state IDLE, counters 0. Reset asynchronous assertion forces these values immediately, including in mid-tile; no done is produced.
- start accepted at edge T0. busy and array_clr at T1. LOAD covers T2..T(K+1). DRAIN covers T(K+2)..T(K+D+1). out_valid from T(K+D+2).
- With out_ready already high: done at T(K+D+3). Start-to-done latency is K + RD_LAT + 2*SysDimension + 3 cycles.
- A new start is accepted in the done cycle, giving back-to-back tiles.
- All outputs are registered.

## Configuration
- SYS_ARRAY_SCHED_PERF_EN defined: adds outputs perf_busy and perf_stall, both 32-bit.
  - perf_busy counts busy cycles.
  - perf_stall counts OUT cycles with out_ready=0.
  - Both saturate at 2^32-1, clear on accepted start, and reset to 0.
- SYS_ARRAY_SCHED_PERF_EN not defined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package sys_array_pkg holds:
  - the state enum (IDLE, CLEAR, LOAD, DRAIN, OUT)
  - LEN_W
  - a function returning the drain length D for given SysDimension and RD_LAT.
- One sub-module, sys_array_cnt: a loadable down-counter with a terminal-count flag, instantiated for the LOAD and DRAIN phases.

## Test plan
- SysDimension=4, RD_LAT=1, K=8, out_ready=1, start at T0:
  - array_clr at T1 only
  - rd_en T2..T9 with addresses 0..7
  - array_en T2..T18
  - out_valid T19, done T20.
- Same setup with out_ready low for 5 cycles: out_valid held T19..T24, array_en=0 throughout, done at T25. With PERF_EN, perf_stall=5.
- K=0 start: done pulse at T1; busy, array_en and out_valid stay 0.
- abort at T6 during LOAD: IDLE at T7, all outputs 0, no done. A restart with K=3 then completes in 3+1+8+3=15 cycles.
- rst asserted during DRAIN: outputs 0 immediately. start while busy is ignored, and the address sequence is unaffected.
- Back-to-back: second start in the done cycle of the first tile. Its CLEAR occurs in the next cycle and the tile completes with identical timing.
